// File: rtl/wb_port_arbiter_if.sv
// Register-file write port bundle: stage-3 writeback, long-unit results,
// and the arbitrated port toward the register file.
interface wb_port_arbiter_if;
  logic        pipe_wb_en;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  modport master (
    output pipe_wb_en, pipe_wb_rd, pipe_wb_data,
    output lu_valid, lu_rd, lu_data,
    input  lu_ready, pipe_stall,
    input  rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  pipe_wb_en, pipe_wb_rd, pipe_wb_data,
    input  lu_valid, lu_rd, lu_data,
    output lu_ready, pipe_stall,
    output rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between stage-3 writeback and a
// buffered long-latency unit, with a starvation-forced one-cycle stall.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst,
  wb_port_arbiter_if.slave bus
);
  logic [1:0]       valid_q;
  logic [1:0]       killed_q;
  logic [1:0][4:0]  rd_q;
  logic [1:0][31:0] data_q;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic [3:0]       wait_cnt;

  logic head_valid;
  logic head_killed;
  logic head_live;
  logic pipe_commit;
  logic head_write;
  logic pop;
  logic push;
  logic push_kill;

  assign head_valid  = valid_q[rd_ptr];
  assign head_killed = killed_q[rd_ptr];
  assign head_live   = head_valid && !head_killed;

  assign bus.pipe_stall = !rst && head_live &&
                          (wait_cnt == 4'(STARVE_LIMIT));

  assign pipe_commit = !rst && bus.pipe_wb_en &&
                       (bus.pipe_wb_rd != 5'd0) && !bus.pipe_stall;

  // A stall hands the port to the head; otherwise the pipeline wins.
  assign head_write = head_live && (bus.pipe_stall || !pipe_commit);

  assign bus.rf_we = pipe_commit || head_write;
  assign bus.rf_wa = head_write ? rd_q[rd_ptr]   : bus.pipe_wb_rd;
  assign bus.rf_wd = head_write ? data_q[rd_ptr] : bus.pipe_wb_data;

  assign pop  = head_valid && (head_write || head_killed);
  assign bus.lu_ready = !rst && (count != 2'd2);
  assign push = bus.lu_valid && bus.lu_ready;

  // Older long-unit results to the same rd are dead once the pipe commits.
  assign push_kill = (bus.lu_rd == 5'd0) ||
                     (pipe_commit && (bus.lu_rd == bus.pipe_wb_rd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      killed_q <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      wait_cnt <= 4'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pipe_commit && valid_q[i] && (rd_q[i] == bus.pipe_wb_rd))
          killed_q[i] <= 1'b1;
      end
      if (pop) begin
        valid_q[rd_ptr]  <= 1'b0;
        killed_q[rd_ptr] <= 1'b0;
        rd_ptr           <= ~rd_ptr;
      end
      if (push) begin
        valid_q[wr_ptr]  <= 1'b1;
        killed_q[wr_ptr] <= push_kill;
        rd_q[wr_ptr]     <= bus.lu_rd;
        data_q[wr_ptr]   <= bus.lu_data;
        wr_ptr           <= ~wr_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (pop || !head_valid)
        wait_cnt <= 4'd0;
      else if (!head_killed)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter: idle drain, backpressure,
// starvation stall, kill, x0 handling and asynchronous reset.
module tb_wb_port_arbiter;
  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        luv;
    logic [4:0]  lurd;
    logic [31:0] ludata;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        stall;
    logic        ready;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic en, input logic [4:0] rd, input logic [31:0] data,
    input logic luv, input logic [4:0] lurd, input logic [31:0] ludata,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic stall, input logic ready);
    vec_t v;
    v.en = en; v.rd = rd; v.data = data;
    v.luv = luv; v.lurd = lurd; v.ludata = ludata;
    v.we = we; v.wa = wa; v.wd = wd;
    v.stall = stall; v.ready = ready;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(
    input logic en, input logic [4:0] rd, input logic [31:0] data,
    input logic luv, input logic [4:0] lurd, input logic [31:0] ludata);
    bus.pipe_wb_en   = en;
    bus.pipe_wb_rd   = rd;
    bus.pipe_wb_data = data;
    bus.lu_valid     = luv;
    bus.lu_rd        = lurd;
    bus.lu_data      = ludata;
  endtask

  task automatic chk_out(input string tag, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic stall, input logic ready);
    chk({tag, ".rf_we"}, 32'(bus.rf_we), 32'(we));
    chk({tag, ".rf_wa"}, 32'(bus.rf_wa), 32'(wa));
    chk({tag, ".rf_wd"}, bus.rf_wd, wd);
    chk({tag, ".stall"}, 32'(bus.pipe_stall), 32'(stall));
    chk({tag, ".ready"}, 32'(bus.lu_ready), 32'(ready));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    drive(1'b1, 5'd7, 32'h70, 1'b1, 5'd3, 32'h30);

    // en  rd  data  luv lurd ludata | we wa wd stall ready
    add(0, 0, 0,    0, 0, 0,           0, 0, 0, 0, 1);
    add(0, 0, 0,    1, 5, 32'hDEADBEEF,0, 0, 0, 0, 1);
    add(0, 0, 0,    0, 0, 0,           1, 5, 32'hDEADBEEF, 0, 1);
    add(0, 0, 0,    0, 0, 0,           0, 0, 0, 0, 1);
    add(1, 1, 'h11, 1, 6, 'h66,        1, 1, 'h11, 0, 1);
    add(1, 1, 'h12, 1, 7, 'h77,        1, 1, 'h12, 0, 1);
    add(1, 1, 'h13, 1, 8, 'h88,        1, 1, 'h13, 0, 0);
    add(1, 1, 'h14, 1, 8, 'h88,        1, 1, 'h14, 0, 0);
    add(1, 1, 'h15, 1, 8, 'h88,        1, 1, 'h15, 0, 0);
    add(1, 1, 'h16, 1, 8, 'h88,        1, 6, 'h66, 1, 0);
    add(1, 1, 'h16, 1, 8, 'h88,        1, 1, 'h16, 0, 1);
    add(1, 1, 'h17, 0, 0, 0,           1, 1, 'h17, 0, 0);
    add(1, 1, 'h18, 0, 0, 0,           1, 1, 'h18, 0, 0);
    add(1, 1, 'h19, 0, 0, 0,           1, 1, 'h19, 0, 0);
    add(1, 1, 'h1A, 0, 0, 0,           1, 7, 'h77, 1, 0);
    add(1, 1, 'h1A, 0, 0, 0,           1, 1, 'h1A, 0, 1);
    add(0, 0, 0,    0, 0, 0,           1, 8, 'h88, 0, 1);
    add(0, 0, 0,    1, 3, 'h33,        0, 0, 0, 0, 1);
    add(1, 3, 'h3C, 0, 0, 0,           1, 3, 'h3C, 0, 1);
    add(0, 0, 0,    0, 0, 0,           0, 0, 0, 0, 1);
    add(1, 3, 'h3D, 1, 3, 'h34,        1, 3, 'h3D, 0, 1);
    add(0, 0, 0,    0, 0, 0,           0, 0, 0, 0, 1);
    add(0, 0, 0,    1, 0, 'h99,        0, 0, 0, 0, 1);
    add(0, 0, 0,    0, 0, 0,           0, 0, 0, 0, 1);
    add(1, 0, 'h55, 1, 10, 'hAA,       0, 0, 'h55, 0, 1);
    add(1, 0, 'h56, 0, 0, 0,           1, 10, 'hAA, 0, 1);
    add(1, 2, 'h22, 0, 0, 0,           1, 2, 'h22, 0, 1);

    @(negedge clk);
    #1;
    chk_out("reset", 1'b0, 5'd7, 32'h70, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].en, vq[i].rd, vq[i].data,
            vq[i].luv, vq[i].lurd, vq[i].ludata);
      #1;
      chk_out($sformatf("vec%0d", i), vq[i].we, vq[i].wa, vq[i].wd,
              vq[i].stall, vq[i].ready);
      @(negedge clk);
    end

    // Fill both entries, then reset in the middle of a cycle.
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC0);
    @(negedge clk);
    drive(1'b1, 5'd1, 32'h2, 1'b1, 5'd13, 32'hD0);
    @(negedge clk);
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    #1;
    chk_out("full", 1'b1, 5'd4, 32'h44, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("midrst", 1'b0, 5'd4, 32'h44, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk_out("postrst0", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk_out("postrst1", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the stage-3 pipeline writeback (the value already selected by the writeback mux) and a long-latency execution unit (divider / multi-cycle load path) that returns results out of band. The pipeline owns the port by default. Long-unit results wait in a 2-entry buffer and drain into idle port cycles. A starvation counter forces a one-cycle pipeline stall when a buffered result has waited too long. The block sits between stage 3 and the register file.

## Interface
- STARVE_LIMIT, 4: cycles a buffer head may wait before a forced stall; legal range 1–15.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- pipe_wb_en  in  1  stage 3 requests a register write this cycle.
- pipe_wb_rd  in  5  stage-3 destination register.
- pipe_wb_data  in  32  stage-3 write data.
- lu_valid  in  1  long unit presents a result.
- lu_rd  in  5  long-unit destination register.
- lu_data  in  32  long-unit result.
- lu_ready  out  1  buffer can accept; transfer occurs on a clock edge where lu_valid && lu_ready.
- pipe_stall  out  1  pipeline must hold stage 3 this cycle.
- rf_we  out  1  register-file write enable.
- rf_wa  out  5  register-file write address.
- rf_wd  out  32  register-file write data.

## Operation
- Buffer: 2-entry circular FIFO. Each entry holds {valid, killed, rd[4:0], data[31:0]}. State also includes 1-bit rd_ptr, 1-bit wr_ptr, a 2-bit count, and a 4-bit wait counter.
- Ordering guarantee: every long-unit result belongs to an instruction older than the one in stage 3. A committed pipeline write therefore supersedes any buffered or incoming result to the same rd.
- Pipeline commit: pipe_commit = pipe_wb_en && pipe_wb_rd != 0 && !pipe_stall.
- Port selection, in priority order:
  - pipe_stall = 1 and head not killed: the port writes the head entry.
  - pipe_commit: the port writes pipe_wb_rd / pipe_wb_data.
  - Otherwise, buffer non-empty and head not killed: the port writes the head entry.
  - Otherwise: rf_we = 0.
- rf_wa and rf_wd follow the selected source. When rf_we = 0 they carry the pipeline values.
- Pop: the head entry pops on any edge where it is written, or where it is killed (a killed head pops with no write, regardless of port use).
- Kill rule, applied at each edge where pipe_commit = 1:
  - every valid entry with rd == pipe_wb_rd sets killed;
  - an entry pushed on the same edge with lu_rd == pipe_wb_rd is written as killed.
- An entry pushed with lu_rd == 0 is always written killed.
- Starvation:
  - the wait counter increments each cycle the head is valid, not killed, and not popped; it clears on pop or when the buffer is empty;
  - pipe_stall = (wait == STARVE_LIMIT) && head valid && !head killed;
  - while stalled, the pipeline's request is ignored. The pipeline holds stage 3 and re-presents the same write next cycle.
- lu_ready = !rst && count != 2. It is evaluated on pre-edge state: a full buffer does not accept a push on the edge where it pops.
- Push and pop on the same edge: count is unchanged and both pointers advance.
- Entries are never bypassed. A result pushed at edge N can first be written in the cycle after edge N.

## Timing
- While rst is high:
  - all entries are invalid; count, pointers and wait are 0;
  - rf_we = 0, pipe_stall = 0, lu_ready = 0;
  - rf_wa and rf_wd follow the pipeline inputs.
- rf_we, rf_wa, rf_wd, pipe_stall and lu_ready are combinational from inputs and registered state. The register file samples them at the next rising edge.
- Best-case latency from long-unit acceptance to write: 1 cycle.
- Worst-case latency with the pipeline writing every cycle: STARVE_LIMIT + 1 cycles for the head entry, plus a further STARVE_LIMIT + 1 for the second entry.
- A forced stall lasts exactly one cycle per starved entry.
- Reset asserted mid-operation discards buffered results with no write. Recovery is the long unit's responsibility.

## Test plan
- Idle port: no pipeline write. Push lu_rd=5, lu_data=0xDEADBEEF at edge 1 -> rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF during cycle 2. Buffer empty after edge 2.
- Full backpressure: pipeline writes every cycle to rd=1; push rd=6 then rd=7 -> lu_ready=0 after the second push. A third lu_valid is held until the first pop.
- Starvation, STARVE_LIMIT=4: pipeline writes every cycle; push rd=9 -> wait reaches 4, then pipe_stall=1 for one cycle with rf_wa=9. Next cycle rf_wa = pipeline rd, and the pipeline write is not lost.
- Kill: buffer holds rd=3 while the pipeline commits rd=3 -> the entry pops with no write. Final rf write to x3 is the pipeline data. Same result when the push and the commit of rd=3 land on the same edge.
- x0 handling: push lu_rd=0 -> no write ever occurs. Pipeline rd=0 with wb_en=1 -> rf_we=0, and a buffered entry drains that cycle.
- Async reset: assert rst mid-cycle with 2 entries buffered -> all outputs take reset values immediately. After release, lu_ready=1 and no stale write occurs.
